// File: rtl/seq_detector_prog_if.sv
// Serial-stream, configuration and status bundle for the
// programmable sequence detector.
interface seq_detector_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               en;
   logic               w;
   logic               cfg_load;
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   pat_len;
   logic               overlap;
   logic               clr_cnt;
   logic               z;
   logic [CNT_W-1:0]   match_count;
   logic               armed;

   modport master (
      output en, w, cfg_load,
      output pat, pat_len, overlap,
      output clr_cnt,
      input  z, match_count, armed
   );

   modport slave (
      input  en, w, cfg_load,
      input  pat, pat_len, overlap,
      input  clr_cnt,
      output z, match_count, armed
   );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with
// overlap control, Moore/Mealy flag and saturating count.
module seq_detector_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8,
   parameter bit MEALY   = 1'b0
) (
   input logic clk,
   input logic reset,
   seq_detector_prog_if.slave bus
);
   localparam int FILL_W = $clog2(MAX_LEN + 1);
   localparam int CW =
      (LEN_W > FILL_W) ? LEN_W : FILL_W;
   localparam logic [FILL_W-1:0] FILL_MAX =
      FILL_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // the oldest history bit is never compared, so
   // only MAX_LEN-1 bits are kept between samples
   logic [MAX_LEN-2:0] hist;
   logic [MAX_LEN-1:0] hist_nx;
   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] mask;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_inc;
   logic [FILL_W-1:0]  fill_nx;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   len_in;
   logic               ovl_q;
   logic               hit;
   logic               sample;
   logic               armed_q;
   logic [CNT_W-1:0]   cnt;

   assign len_in =
      (32'(bus.pat_len) > MAX_LEN) ?
      LEN_W'(MAX_LEN) : bus.pat_len;

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len_q));
   end

   assign sample  = bus.en & ~bus.cfg_load;
   assign hist_nx = {hist, bus.w};

   assign fill_inc =
      (fill == FILL_MAX) ? fill : fill + 1'b1;

   assign hit =
      (len_q != '0) &&
      (CW'(fill_inc) >= CW'(len_q)) &&
      (((hist_nx ^ pat_q) & mask) == '0);

   assign fill_nx =
      (hit && !ovl_q) ? '0 : fill_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist    <= '0;
         fill    <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         armed_q <= 1'b0;
      end else if (bus.cfg_load) begin
         hist    <= '0;
         fill    <= '0;
         pat_q   <= bus.pat;
         len_q   <= len_in;
         ovl_q   <= bus.overlap;
         armed_q <= 1'b0;
      end else if (bus.en) begin
         hist    <= hist_nx[MAX_LEN-2:0];
         fill    <= fill_nx;
         armed_q <= (len_q != '0) &&
                    (CW'(fill_nx) >= CW'(len_q));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (bus.clr_cnt)
         cnt <= '0;
      else if (sample && hit && cnt != CNT_MAX)
         cnt <= cnt + 1'b1;
   end

   generate
      if (MEALY) begin : g_mealy
         assign bus.z = sample & hit;
      end else begin : g_moore
         logic z_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               z_q <= 1'b0;
            else
               z_q <= sample & hit;
         end
         assign bus.z = z_q;
      end
   endgenerate

   assign bus.match_count = cnt;
   assign bus.armed       = armed_q;
endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: a Moore/8-bit-count and a
// Mealy/2-bit-count instance against a queue-based model.
module tb_seq_detector_prog;
   localparam int ML = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seq_detector_prog_if #(
      .MAX_LEN(ML), .LEN_W(4), .CNT_W(8)
   ) b0 ();
   seq_detector_prog_if #(
      .MAX_LEN(ML), .LEN_W(4), .CNT_W(2)
   ) b1 ();

   seq_detector_prog #(
      .MAX_LEN(ML), .LEN_W(4), .CNT_W(8), .MEALY(1'b0)
   ) d0 (.clk(clk), .reset(reset), .bus(b0));

   seq_detector_prog #(
      .MAX_LEN(ML), .LEN_W(4), .CNT_W(2), .MEALY(1'b1)
   ) d1 (.clk(clk), .reset(reset), .bus(b1));

   int checks = 0;
   int failures = 0;

   logic [ML-1:0] d_pat = '0;
   logic [3:0]    d_len = '0;
   bit            d_ovl = 1'b0;

   // model: bits received since the last flush, oldest first
   bit            mq[$];
   int            m_len = 0;
   logic [ML-1:0] m_pat = '0;
   bit            m_ovl = 1'b0;
   int            c8 = 0;
   int            c2 = 0;

   task automatic chk(string tag,
                      logic [31:0] obs,
                      logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   function automatic bit model_hit(bit wb);
      bit t[$];
      int n;
      t = mq;
      t.push_back(wb);
      if (t.size() > ML) void'(t.pop_front());
      n = t.size();
      if (m_len == 0 || n < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++)
         if (t[n-m_len+i] != m_pat[m_len-1-i])
            return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive(bit en, bit w, bit cfg, bit clr);
      b0.en = en;        b1.en = en;
      b0.w = w;          b1.w = w;
      b0.cfg_load = cfg; b1.cfg_load = cfg;
      b0.clr_cnt = clr;  b1.clr_cnt = clr;
      b0.pat = d_pat;    b1.pat = d_pat;
      b0.pat_len = d_len; b1.pat_len = d_len;
      b0.overlap = d_ovl; b1.overlap = d_ovl;
   endtask

   task automatic check_all(string tag, bit ez);
      bit arm;
      arm = (m_len != 0) && (mq.size() >= m_len);
      chk({tag, "_z"},    32'(b0.z), 32'(ez));
      chk({tag, "_cnt8"}, 32'(b0.match_count), c8);
      chk({tag, "_cnt2"}, 32'(b1.match_count), c2);
      chk({tag, "_arm0"}, 32'(b0.armed), 32'(arm));
      chk({tag, "_arm1"}, 32'(b1.armed), 32'(arm));
   endtask

   task automatic step(bit en, bit w, bit cfg, bit clr);
      bit h;
      @(negedge clk);
      drive(en, w, cfg, clr);
      #1;
      h = en && !cfg && model_hit(w);
      chk("mealy_z", 32'(b1.z), 32'(h));
      @(posedge clk);
      if (cfg) begin
         m_pat = d_pat;
         m_len = (d_len > ML) ? ML : int'(d_len);
         m_ovl = d_ovl;
         mq.delete();
      end else if (en) begin
         mq.push_back(w);
         if (mq.size() > ML) void'(mq.pop_front());
         if (h && !m_ovl) mq.delete();
      end
      if (clr) begin
         c8 = 0;
         c2 = 0;
      end else if (h) begin
         if (c8 < 255) c8++;
         if (c2 < 3) c2++;
      end
      #1;
      check_all("step", h);
   endtask

   task automatic load(logic [ML-1:0] p, logic [3:0] l,
                       bit o);
      d_pat = p;
      d_len = l;
      d_ovl = o;
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic feed(logic [15:0] bits, int n);
      for (int i = n - 1; i >= 0; i--)
         step(1'b1, bits[i], 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_z0",   32'(b0.z), 0);
      chk("rst_z1",   32'(b1.z), 0);
      chk("rst_cnt0", 32'(b0.match_count), 0);
      chk("rst_cnt1", 32'(b1.match_count), 0);
      chk("rst_arm0", 32'(b0.armed), 0);
      mq.delete();
      m_len = 0;
      m_pat = '0;
      m_ovl = 1'b0;
      c8 = 0;
      c2 = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("init_z0",   32'(b0.z), 0);
      chk("init_cnt0", 32'(b0.match_count), 0);
      chk("init_arm0", 32'(b0.armed), 0);
      chk("init_arm1", 32'(b1.armed), 0);
      @(negedge clk);
      reset = 1'b0;

      // overlapping 1011 on 1011011
      load(8'b0000_1011, 4'd4, 1'b1);
      feed(16'b101_1011, 7);
      chk("ovl_count", 32'(b0.match_count), 2);

      // non-overlapping on the same stream
      step(1'b0, 1'b0, 1'b0, 1'b1);
      load(8'b0000_1011, 4'd4, 1'b0);
      feed(16'b101_1011, 7);
      chk("novl_count", 32'(b0.match_count), 1);

      // en gap in the middle of a match
      load(8'b0000_1011, 4'd4, 1'b0);
      feed(16'b101, 3);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("gap_z", 32'(b0.z), 1);

      // reload discards history and the bit on that edge
      step(1'b0, 1'b0, 1'b0, 1'b1);
      load(8'b0000_0101, 4'd3, 1'b1);
      feed(16'b10, 2);
      d_pat = 8'b0000_0001;
      d_len = 4'd2;
      d_ovl = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      feed(16'b01, 2);
      chk("reload_count", 32'(b0.match_count), 1);

      // 2-bit counter saturation, clear beats increment
      step(1'b0, 1'b0, 1'b0, 1'b1);
      load(8'b0000_0001, 4'd1, 1'b0);
      feed(16'b11111, 5);
      chk("sat_cnt2", 32'(b1.match_count), 3);
      chk("sat_cnt8", 32'(b0.match_count), 5);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("clr_cnt2", 32'(b1.match_count), 0);

      // reset during a partial match leaves it disabled
      load(8'b0000_1011, 4'd4, 1'b1);
      feed(16'b101, 3);
      do_reset();
      feed(16'b1011, 4);
      chk("postrst_cnt", 32'(b0.match_count), 0);

      // pattern length above MAX_LEN clamps
      load(8'b1111_1111, 4'd12, 1'b1);
      feed(16'hFFFF, 9);

      // random configs, pin noise between loads
      for (int k = 0; k < 8; k++) begin
         d_len = 4'($urandom_range(0, 10));
         d_pat = 8'($urandom);
         d_ovl = 1'($urandom);
         step(1'b0, 1'b0, 1'b1, 1'b0);
         for (int j = 0; j < 70; j++) begin
            d_pat = 8'($urandom);
            d_len = 4'($urandom);
            d_ovl = 1'($urandom);
            step($urandom_range(0, 9) < 8,
                 1'($urandom),
                 $urandom_range(0, 60) == 0,
                 $urandom_range(0, 40) == 0);
         end
         if (k == 4) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
